// File: rtl/digit_scan_if.sv
// Signal bundle between the digit scan controller and its host/decoder side.
// Names carry the controller's point of view (_i into it, _o out of it).
interface digit_scan_if;
  logic       en_i;
  logic [3:0] digit_mask_i;
  logic [1:0] sel_o;
  logic       sel_valid_o;
  logic       frame_done_o;

  modport master (
    output en_i,
    output digit_mask_i,
    input  sel_o,
    input  sel_valid_o,
    input  frame_done_o
  );

  modport slave (
    input  en_i,
    input  digit_mask_i,
    output sel_o,
    output sel_valid_o,
    output frame_done_o
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller: walks the enabled digits, PRESCALE cycles
// shown then BLANK dark cycles each, pulsing frame_done when the index wraps.
module digit_scan_ctrl #(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1
) (
  input  logic        clk,
  input  logic        rst,
  digit_scan_if.slave bus
);

  localparam int CNT_MAX = (PRESCALE > BLANK) ? ((PRESCALE > 2) ? PRESCALE : 2)
                                              : ((BLANK > 2) ? BLANK : 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] PS_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BL_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          sel_valid_q, sel_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          adv_s;

  function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) idx = 2'(i);
      else         idx = idx;
    end
    return idx;
  endfunction

  // Smallest cyclic step wins; if no other bit is set the current index repeats.
  function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] idx;
    logic [1:0] cand;
    idx = cur;
    for (int k = 3; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (mask[cand]) idx = cand;
      else            idx = idx;
    end
    return idx;
  endfunction

  // Next-state, counter, index and frame-wrap decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    adv_s        = 1'b0;

    if (!bus.en_i) begin
      state_d = S_IDLE;
      cnt_d   = {CW{1'b0}};
      sel_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.digit_mask_i != 4'b0000) begin
            state_d = S_SHOW;
            sel_d   = lowest_idx(bus.digit_mask_i);
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = S_IDLE;
            sel_d   = 2'd0;
          end
        end
        S_SHOW: begin
          if (cnt_q == PS_LAST) begin
            if (BLANK == 0) begin
              adv_s = 1'b1;
            end else begin
              state_d = S_BLANK;
              cnt_d   = {CW{1'b0}};
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_BLANK: begin
          if (cnt_q == BL_LAST) adv_s = 1'b1;
          else                  cnt_d = cnt_q + CW'(1);
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CW{1'b0}};
          sel_d   = 2'd0;
        end
      endcase

      if (adv_s) begin
        cnt_d = {CW{1'b0}};
        if (bus.digit_mask_i == 4'b0000) begin
          state_d = S_IDLE;
          sel_d   = 2'd0;
        end else begin
          state_d      = S_SHOW;
          sel_d        = next_idx(sel_q, bus.digit_mask_i);
          frame_done_d = (sel_d <= sel_q);
        end
      end else begin
        frame_done_d = 1'b0;
      end
    end

    sel_valid_d = (state_d == S_SHOW);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      sel_q        <= 2'd0;
      sel_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sel_o        = sel_q;
  assign bus.sel_valid_o  = sel_valid_q;
  assign bus.frame_done_o = frame_done_q;

endmodule
